// File: rtl/seq_ab_cd_checker.sv
// seq_ab_cd_checker: hardware checker for a ##1 b ##1 c ##2 d with pass/fail pulses, saturating counts and first-failure capture
module seq_ab_cd_checker #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy,
  output logic             err_valid,
  output logic [2:0]       err_stage,
  output logic [TS_W-1:0]  err_time
);
  localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};
  logic s1, s2, s3, s4;
  logic [TS_W-1:0] timer;
  logic pass, f1, f2, f3, f4, any_fail;
  logic [2:0] nfail, stage;
  logic [CNT_W+2:0] pass_sum, fail_sum;
  logic [CNT_W-1:0] pass_nxt, fail_nxt;
  assign pass = s4 & d;
  assign f1 = s1 & ~b;
  assign f2 = s2 & ~c;
  assign f3 = s4 & ~d;
`ifdef SEQ_CHK_STRICT_EN
  assign f4 = en & ~a;
`else
  assign f4 = 1'b0;
`endif
  assign any_fail = f1 | f2 | f3 | f4;
  assign busy = s1 | s2 | s3 | s4;
  always_comb begin
    nfail = {2'b00, f1} + {2'b00, f2} + {2'b00, f3} + {2'b00, f4};
    stage = f3 ? 3'd3 : f2 ? 3'd2 : f1 ? 3'd1 : 3'd4;
    pass_sum = {3'b000, pass_cnt} + {{(CNT_W+2){1'b0}}, pass};
    fail_sum = {3'b000, fail_cnt} + {{CNT_W{1'b0}}, nfail};
    pass_nxt = (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
    fail_nxt = (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, s3, s4} <= '0;
      timer      <= '0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_valid  <= 1'b0;
      err_stage  <= '0;
      err_time   <= '0;
    end else if (clr) begin
      {s1, s2, s3, s4} <= '0;
      timer      <= '0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_valid  <= 1'b0;
      err_stage  <= '0;
      err_time   <= '0;
    end else begin
      s1         <= en & a;
      s2         <= s1 & b;
      s3         <= s2 & c;
      s4         <= s3;
      timer      <= timer + 1'b1;
      pass_pulse <= pass;
      fail_pulse <= any_fail;
      pass_cnt   <= pass_nxt;
      fail_cnt   <= fail_nxt;
      if (!err_valid && any_fail) begin
        err_valid <= 1'b1;
        err_stage <= stage;
        err_time  <= timer;
      end
    end
  end
endmodule
